layer_mem_arbiter: RTL and testbench

Round-robin arbiter that shares the single layer-memory port (`csel`/`crd`/`cwr`) of the ATCONV accelerator among three requesters: 0 = convolution writer, 1 = max-pool reader/writer, 2 = host/readback. Each requester sees a valid/grant access channel and a tagged read-return path. A lock bit lets a requester own the port for an uninterrupted burst, such as the four reads of a 2x2 pooling window. The block sits between the ATCONV datapath and the layer memory banks and is the only driver of the memory-side signals.

---
 rtl/layer_mem_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_layer_mem_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_mem_arbiter.sv
// Three-way round-robin arbiter with burst lock for the shared ATCONV layer-memory port.
// Grants are combinational; memory drive and tagged read returns are registered.
module layer_mem_arbiter #(
  parameter int AW = 12,
  parameter int DW = 13,
  parameter int N  = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    lock,
  input  logic [N-1:0]    we,
  input  logic [N-1:0]    sel,
  input  logic [N*AW-1:0] addr,
  input  logic [N*DW-1:0] wdata,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    rvalid,
  output logic [DW-1:0]   rdata,
  output logic            cwr,
  output logic [AW-1:0]   caddr_wr,
  output logic [DW-1:0]   cdata_wr,
  output logic            crd,
  output logic [AW-1:0]   caddr_rd,
  input  logic [DW-1:0]   cdata_rd,
  output logic            csel
);

  typedef logic [1:0] id_t;

  typedef struct packed {
    logic valid;
    id_t  id;
  } tag_t;

  function automatic id_t id_add(input id_t a, input id_t b);
    logic [2:0] s;
    logic [2:0] t;
    s = {1'b0, a} + {1'b0, b};
    t = s - 3'd3;
    return (s >= 3'd3) ? t[1:0] : s[1:0];
  endfunction

  id_t            ptr_q, ptr_d;
  id_t            owner_q, owner_d;
  logic           owner_valid_q, owner_valid_d;
  logic           cwr_q, cwr_d;
  logic           crd_q, crd_d;
  logic           csel_q, csel_d;
  logic [AW-1:0]  caddr_wr_q, caddr_wr_d;
  logic [AW-1:0]  caddr_rd_q, caddr_rd_d;
  logic [DW-1:0]  cdata_wr_q, cdata_wr_d;
  tag_t           tag0_q, tag0_d;
  tag_t           tag1_q, tag1_d;
  logic [N-1:0]   rvalid_q, rvalid_d;
  logic [DW-1:0]  rdata_q, rdata_d;

  logic [N-1:0]   gnt_c;
  logic           xfer;
  id_t            win;
  logic           w_we, w_sel, w_lock;
  logic [AW-1:0]  w_addr;
  logic [DW-1:0]  w_wdata;

  // Grant: a valid owner keeps the port; otherwise search upward from ptr.
  always_comb begin
    id_t  cand;
    logic found;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    gnt_c = '0;
    found = 1'b0;
    cand  = '0;
    if (!reset) begin
      if (owner_valid_q) begin
        gnt_c[owner_q] = req[owner_q];
      end else begin
        for (int k = 0; k < N; k++) begin
          cand = id_add(ptr_q, id_t'(k));
          if (!found && req[cand]) begin
            gnt_c[cand] = 1'b1;
            found       = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    xfer    = 1'b0;
    win     = '0;
    w_we    = 1'b0;
    w_sel   = 1'b0;
    w_lock  = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_c[i]) begin
        xfer    = 1'b1;
        win     = id_t'(i);
        w_we    = we[i];
        w_sel   = sel[i];
        w_lock  = lock[i];
        w_addr  = addr[i*AW +: AW];
        w_wdata = wdata[i*DW +: DW];
      end
    end
  end

  always_comb begin
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    owner_valid_d = owner_valid_q;
    // An owner that stops requesting gives the port up on this edge.
    if (owner_valid_q && !req[owner_q]) owner_valid_d = 1'b0;
    if (xfer) begin
      ptr_d         = id_add(win, 2'd1);
      owner_d       = win;
      owner_valid_d = w_lock;
    end

    cwr_d      = xfer & w_we;
    crd_d      = xfer & ~w_we;
    csel_d     = csel_q;
    caddr_wr_d = caddr_wr_q;
    caddr_rd_d = caddr_rd_q;
    cdata_wr_d = cdata_wr_q;
    if (xfer) begin
      csel_d = w_sel;
      if (w_we) begin
        caddr_wr_d = w_addr;
        cdata_wr_d = w_wdata;
      end else begin
        caddr_rd_d = w_addr;
      end
    end

    // tag0 lines up with crd, tag1 with cdata_rd from the memory.
    tag0_d.valid = crd_d;
    tag0_d.id    = win;
    tag1_d       = tag0_q;
    rvalid_d     = '0;
    rdata_d      = rdata_q;
    if (tag1_q.valid) begin
      rvalid_d[tag1_q.id] = 1'b1;
      rdata_d             = cdata_rd;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q         <= '0;
      owner_q       <= '0;
      owner_valid_q <= 1'b0;
      cwr_q         <= 1'b0;
      crd_q         <= 1'b0;
      csel_q        <= 1'b0;
      caddr_wr_q    <= '0;
      caddr_rd_q    <= '0;
      cdata_wr_q    <= '0;
      tag0_q        <= '0;
      tag1_q        <= '0;
      rvalid_q      <= '0;
      rdata_q       <= '0;
    end else begin
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      owner_valid_q <= owner_valid_d;
      cwr_q         <= cwr_d;
      crd_q         <= crd_d;
      csel_q        <= csel_d;
      caddr_wr_q    <= caddr_wr_d;
      caddr_rd_q    <= caddr_rd_d;
      cdata_wr_q    <= cdata_wr_d;
      tag0_q        <= tag0_d;
      tag1_q        <= tag1_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
    end
  end

  assign gnt      = gnt_c;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign cwr      = cwr_q;
  assign crd      = crd_q;
  assign csel     = csel_q;
  assign caddr_wr = caddr_wr_q;
  assign caddr_rd = caddr_rd_q;
  assign cdata_wr = cdata_wr_q;

endmodule

// File: tb/tb_layer_mem_arbiter.sv
// Self-checking bench for layer_mem_arbiter: queued requester drivers, a memory bank,
// and a cycle-level reference model of arbitration, lock, memory drive and read return.
module tb_layer_mem_arbiter;
  localparam int AW = 12;
  localparam int DW = 13;
  localparam int N  = 3;
  localparam int QD = 128;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req, lock, we, sel;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata, cdata_wr, cdata_rd;
  logic            cwr, crd, csel;
  logic [AW-1:0]   caddr_wr, caddr_rd;

  layer_mem_arbiter #(.AW(AW), .DW(DW), .N(N)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we), .sel(sel),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .crd(crd),
    .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel)
  );

  always #5 clk = ~clk;

  // Layer memory bank: write on cwr, read data appears the cycle after crd.
  logic [DW-1:0] bank [2][4096];
  always @(posedge clk) begin
    if (cwr) bank[csel][caddr_wr] <= cdata_wr;
    if (crd) cdata_rd <= bank[csel][caddr_rd];
  end

  typedef struct {
    logic          we;
    logic          sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          lock;
    int            gap;
  } acc_t;

  acc_t abuf [3][QD];
  int   hd [3];
  int   tl [3];

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;

  // Reference model state
  int            m_ptr, m_owner;
  bit            m_ov;
  logic [DW-1:0] ref_mem [int];
  logic          e_cwr, e_crd, e_csel;
  logic [AW-1:0] e_caddr_wr, e_caddr_rd;
  logic [DW-1:0] e_cdata_wr, e_rdata;
  logic [N-1:0]  e_rvalid;
  bit            p_v [2];
  int            p_id [2];
  logic [DW-1:0] p_d [2];

  // Observation logs
  int            obs_w [$];
  int            obs_cyc [$];
  int            ret_id [$];
  int            ret_cyc [$];
  logic [DW-1:0] ret_d [$];

  logic [DW-1:0] pool_d [8];

  task automatic push(input int r, input logic w, input logic s, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic lk, input int g);
    abuf[r][tl[r]] = '{we: w, sel: s, addr: a, wdata: d, lock: lk, gap: g};
    tl[r]++;
  endtask

  function automatic string obs_str();
    string s = "";
    foreach (obs_w[i]) s = {s, $sformatf("%0d", obs_w[i])};
    return s;
  endfunction

  function automatic string ret_str();
    string s = "";
    foreach (ret_id[i]) s = {s, $sformatf("%0d", ret_id[i])};
    return s;
  endfunction

  function automatic bit pending();
    bit p = p_v[0] | p_v[1];
    for (int i = 0; i < 3; i++) if (hd[i] != tl[i]) p = 1;
    return p;
  endfunction

  task automatic clear_logs();
    obs_w.delete(); obs_cyc.delete(); ret_id.delete(); ret_cyc.delete(); ret_d.delete();
  endtask

  task automatic apply_reset();
    req = '0; lock = '0; we = '0; sel = '0; addr = '0; wdata = '0;
    reset = 1'b1;
    #1;
    chk_cnt++;
    if ({gnt, rvalid, rdata, cwr, crd, caddr_wr, caddr_rd, cdata_wr, csel} !== '0)
      $display("FAIL reset_outputs gnt=%b rvalid=%b rdata=%h cwr=%b crd=%b caddr_wr=%h caddr_rd=%h cdata_wr=%h csel=%b required all 0",
               gnt, rvalid, rdata, cwr, crd, caddr_wr, caddr_rd, cdata_wr, csel);
    else pass_cnt++;
    m_ptr = 0; m_owner = 0; m_ov = 0;
    e_cwr = 0; e_crd = 0; e_csel = 0; e_caddr_wr = '0; e_caddr_rd = '0; e_cdata_wr = '0;
    e_rdata = '0; e_rvalid = '0;
    for (int i = 0; i < 2; i++) begin p_v[i] = 0; p_id[i] = 0; p_d[i] = '0; end
    for (int i = 0; i < 3; i++) begin hd[i] = 0; tl[i] = 0; end
    @(posedge clk); #1;
    cyc++;
    reset = 1'b0;
  endtask

  // One clock cycle: drive queue heads, check grant, advance model, check registered outputs.
  task automatic do_cycle();
    logic [N-1:0]  eg;
    logic [DW-1:0] new_d;
    bit            new_v;
    int            mw, key;
    acc_t          a;
    req = '0; lock = '0; we = '0; sel = '0; addr = '0; wdata = '0;
    for (int i = 0; i < 3; i++) begin
      if (hd[i] != tl[i] && abuf[i][hd[i]].gap == 0) begin
        a = abuf[i][hd[i]];
        req[i] = 1'b1; lock[i] = a.lock; we[i] = a.we; sel[i] = a.sel;
        addr[i*AW +: AW] = a.addr; wdata[i*DW +: DW] = a.wdata;
      end
    end
    @(negedge clk);
    eg = '0; mw = -1;
    if (m_ov) begin
      if (req[m_owner]) begin eg[m_owner] = 1'b1; mw = m_owner; end
    end else begin
      for (int k = 0; k < 3; k++) begin
        int j;
        j = (m_ptr + k) % 3;
        if (mw < 0 && req[j]) begin eg[j] = 1'b1; mw = j; end
      end
    end
    chk_cnt++;
    if (gnt !== eg) $display("FAIL gnt cyc=%0d req=%b got=%b required=%b", cyc, req, gnt, eg);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) if (req[i] & gnt[i]) begin obs_w.push_back(i); obs_cyc.push_back(cyc); end

    if (m_ov && !req[m_owner]) m_ov = 0;
    for (int i = 0; i < 3; i++)
      if (hd[i] != tl[i] && abuf[i][hd[i]].gap > 0) abuf[i][hd[i]].gap = abuf[i][hd[i]].gap - 1;
    e_cwr = 0; e_crd = 0; new_v = 0; new_d = '0;
    if (mw >= 0) begin
      a = abuf[mw][hd[mw]];
      key = int'({a.sel, a.addr});
      m_ptr = (mw + 1) % 3; m_owner = mw; m_ov = a.lock;
      e_csel = a.sel;
      if (a.we) begin
        e_cwr = 1; e_caddr_wr = a.addr; e_cdata_wr = a.wdata; ref_mem[key] = a.wdata;
      end else begin
        e_crd = 1; e_caddr_rd = a.addr; new_v = 1;
        new_d = ref_mem.exists(key) ? ref_mem[key] : '0;
      end
      hd[mw]++;
    end
    e_rvalid = '0;
    if (p_v[1]) begin e_rvalid[p_id[1]] = 1'b1; e_rdata = p_d[1]; end
    p_v[1] = p_v[0]; p_id[1] = p_id[0]; p_d[1] = p_d[0];
    p_v[0] = new_v;  p_id[0] = mw;      p_d[0] = new_d;

    @(posedge clk); #1;
    cyc++;
    chk_cnt++;
    if ({cwr, crd, csel} !== {e_cwr, e_crd, e_csel})
      $display("FAIL strobes cyc=%0d cwr/crd/csel got=%b%b%b required=%b%b%b", cyc, cwr, crd, csel, e_cwr, e_crd, e_csel);
    else pass_cnt++;
    chk_cnt++;
    if ({caddr_wr, cdata_wr, caddr_rd} !== {e_caddr_wr, e_cdata_wr, e_caddr_rd})
      $display("FAIL mem_bus cyc=%0d caddr_wr=%h cdata_wr=%h caddr_rd=%h required %h %h %h",
               cyc, caddr_wr, cdata_wr, caddr_rd, e_caddr_wr, e_cdata_wr, e_caddr_rd);
    else pass_cnt++;
    chk_cnt++;
    if ({rvalid, rdata} !== {e_rvalid, e_rdata})
      $display("FAIL read_return cyc=%0d rvalid=%b rdata=%h required rvalid=%b rdata=%h", cyc, rvalid, rdata, e_rvalid, e_rdata);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) if (rvalid[i]) begin ret_id.push_back(i); ret_d.push_back(rdata); ret_cyc.push_back(cyc); end
  endtask

  task automatic run_all(input int max_cycles);
    int n = 0;
    while (pending() && n < max_cycles) begin do_cycle(); n++; end
    if (pending()) begin
      chk_cnt++;
      $display("FAIL timeout queues not drained after %0d cycles", max_cycles);
    end
    do_cycle();
  endtask

  task automatic preload_pool();
    for (int k = 0; k < 8; k++) begin
      pool_d[k] = DW'($urandom);
      push(0, 1'b1, 1'b0, AW'(12'h200 + k), pool_d[k], 1'b0, 0);
    end
    run_all(40);
  endtask

  task automatic test_reset();
    apply_reset();
    do_cycle();
    do_cycle();
  endtask

  task automatic test_simultaneous();
    apply_reset();
    clear_logs();
    push(0, 1'b1, 1'b0, 12'h010, 13'h0abc, 1'b0, 0);
    push(1, 1'b0, 1'b0, 12'h010, 13'h0000, 1'b0, 0);
    push(2, 1'b1, 1'b1, 12'h7ff, 13'h1234, 1'b0, 0);
    run_all(20);
    chk_cnt++;
    if (obs_str() != "012" || obs_cyc.size() != 3 || obs_cyc[2] - obs_cyc[0] != 2)
      $display("FAIL simultaneous_order got=%s required=012 on consecutive edges", obs_str());
    else pass_cnt++;
    chk_cnt++;
    if (ret_d.size() != 1 || ret_d[0] !== 13'h0abc)
      $display("FAIL simultaneous_read got %0d returns required 1 with data 0abc", ret_d.size());
    else pass_cnt++;
    clear_logs();
    push(2, 1'b1, 1'b0, 12'h020, 13'h0001, 1'b0, 0);
    push(1, 1'b1, 1'b0, 12'h021, 13'h0002, 1'b0, 0);
    run_all(20);
    chk_cnt++;
    if (obs_str() != "12") $display("FAIL ptr_wrap got=%s required=12", obs_str());
    else pass_cnt++;
  endtask

  task automatic test_write_read();
    apply_reset();
    clear_logs();
    push(0, 1'b1, 1'b1, 12'h041, 13'h0150, 1'b0, 0);
    push(2, 1'b0, 1'b1, 12'h041, 13'h0000, 1'b0, 0);
    run_all(20);
    chk_cnt++;
    if (obs_str() != "02") $display("FAIL wr_rd_order got=%s required=02", obs_str());
    else pass_cnt++;
    chk_cnt++;
    if (ret_str() != "2" || ret_d[0] !== 13'h0150 || ret_cyc[0] != obs_cyc[1] + 3)
      $display("FAIL wr_rd_return ids=%s required=2 data=%h required=0150", ret_str(), (ret_d.size() > 0) ? ret_d[0] : 13'h0);
    else pass_cnt++;
  endtask

  task automatic test_locked_burst();
    logic [DW-1:0] d [4];
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      d[k] = DW'($urandom);
      push(0, 1'b1, 1'b0, AW'(12'h100 + k), d[k], 1'b0, 0);
    end
    run_all(20);
    clear_logs();
    for (int k = 0; k < 4; k++) push(1, 1'b0, 1'b0, AW'(12'h100 + k), 13'h0, (k < 3), 0);
    for (int k = 0; k < 3; k++) push(0, 1'b1, 1'b1, AW'(12'h300 + k), DW'($urandom), 1'b0, 0);
    run_all(30);
    chk_cnt++;
    if (obs_str() != "1111000" || obs_cyc[6] - obs_cyc[0] != 6)
      $display("FAIL locked_burst_order got=%s required=1111000 back to back", obs_str());
    else pass_cnt++;
    chk_cnt++;
    if (ret_str() != "1111" || ret_d[0] !== d[0] || ret_d[1] !== d[1] || ret_d[2] !== d[2] || ret_d[3] !== d[3])
      $display("FAIL locked_burst_returns ids=%s required=1111 in address order", ret_str());
    else pass_cnt++;
  endtask

  task automatic test_lock_drop();
    apply_reset();
    push(1, 1'b1, 1'b0, 12'h050, 13'h0055, 1'b0, 0);
    run_all(10);
    clear_logs();
    push(2, 1'b1, 1'b0, 12'h051, 13'h0066, 1'b1, 0);
    push(1, 1'b1, 1'b0, 12'h052, 13'h0077, 1'b0, 0);
    run_all(10);
    chk_cnt++;
    if (obs_str() != "21" || obs_cyc[1] - obs_cyc[0] != 2)
      $display("FAIL lock_drop got=%s required=21 with one idle cycle", obs_str());
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_read();
    apply_reset();
    clear_logs();
    push(1, 1'b0, 1'b0, 12'h041, 13'h0, 1'b0, 0);
    do_cycle();
    do_cycle();
    clear_logs();
    apply_reset();
    for (int k = 0; k < 4; k++) do_cycle();
    chk_cnt++;
    if (ret_id.size() != 0) $display("FAIL reset_mid_read got %0d returns required 0", ret_id.size());
    else pass_cnt++;
    push(2, 1'b1, 1'b0, 12'h060, 13'h0011, 1'b0, 0);
    push(0, 1'b1, 1'b0, 12'h061, 13'h0022, 1'b0, 0);
    run_all(10);
    chk_cnt++;
    if (obs_str() != "02") $display("FAIL post_reset_ptr got=%s required=02", obs_str());
    else pass_cnt++;
  endtask

  task automatic test_fairness();
    string exp_s = "";
    int    cnt [3];
    apply_reset();
    preload_pool();
    apply_reset();
    clear_logs();
    for (int k = 0; k < 10; k++)
      for (int r = 0; r < 3; r++)
        push(r, 1'($urandom), 1'b0, AW'(12'h200 + $urandom_range(7)), DW'($urandom), 1'b0, 0);
    run_all(60);
    for (int k = 0; k < 10; k++) exp_s = {exp_s, "012"};
    cnt = '{0, 0, 0};
    foreach (obs_w[i]) cnt[obs_w[i]]++;
    chk_cnt++;
    if (cnt[0] != 10 || cnt[1] != 10 || cnt[2] != 10)
      $display("FAIL fairness_counts got=%0d/%0d/%0d required=10/10/10", cnt[0], cnt[1], cnt[2]);
    else pass_cnt++;
    chk_cnt++;
    if (obs_str() != exp_s || obs_cyc[29] - obs_cyc[0] != 29)
      $display("FAIL fairness_rotation got=%s required strict 012 rotation", obs_str());
    else pass_cnt++;
  endtask

  task automatic test_random();
    int nreads = 0;
    clear_logs();
    for (int k = 0; k < 25; k++)
      for (int r = 0; r < 3; r++) begin
        logic w;
        w = 1'($urandom);
        if (!w) nreads++;
        push(r, w, 1'b0, AW'(12'h200 + $urandom_range(7)), DW'($urandom),
             ($urandom_range(3) == 0), $urandom_range(2));
      end
    run_all(2000);
    chk_cnt++;
    if (ret_id.size() != nreads) $display("FAIL random_return_count got=%0d required=%0d", ret_id.size(), nreads);
    else pass_cnt++;
  endtask

  initial begin
    #2;
    test_reset();
    test_simultaneous();
    test_write_read();
    test_locked_burst();
    test_lock_drop();
    test_reset_mid_read();
    test_fairness();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
